// File: rtl/mem_block_mover_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg (package)
// Description : Shared defaults and types for the memory block mover:
//               address/data width defaults, the mover FSM state type and
//               the legal read-latency range.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Read latency of the attached memory may be 0..RD_LAT_MAX cycles.
    localparam int RD_LAT_MAX = 2;

    // Wide enough to count the wait cycles of the slowest legal memory.
    localparam int WAIT_CNT_W = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_block_mover_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_mover_if
// Description : Initiator-to-DataMemory bus.
//               master : drives mem_addr, mem_wdata, mem_write, mem_read;
//                        receives mem_rdata
//               slave  : the memory side (mirror of master)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_block_mover_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_write,
        output mem_read,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_write,
        input  mem_read,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_addr_stepper.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_stepper
// Description : Word pointer that can be loaded or stepped by one in either
//               direction; arithmetic wraps modulo 2^ADDR_W.
//   clk, rst    : clock, synchronous active-high reset (pointer -> 0)
//   i_load      : load i_load_val (has priority over i_step)
//   i_step      : advance pointer by one
//   i_up        : 1 = increment, 0 = decrement
//   i_load_val  : value to load
//   o_ptr       : current pointer
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_stepper
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               i_load,
    input  wire               i_step,
    input  wire               i_up,
    input  wire  [ADDR_W-1:0] i_load_val,
    output logic [ADDR_W-1:0] o_ptr
);

    logic [ADDR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_val;
        end else if (i_step) begin
            r_ptr <= i_up ? (r_ptr + ADDR_W'(1)) : (r_ptr - ADDR_W'(1));
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/mem_block_mover.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_mover
// Description : Copies LEN words from SRC to DST through a DataMemory port,
//               one read then one write per word, choosing a descending
//               order when the destination overlaps the tail of the source.
//   clk, rst          : clock, synchronous active-high reset
//   start             : request a copy (accepted only when idle)
//   src_addr/dst_addr : first source/destination word address
//   len               : word count
//   busy              : high while a copy is running
//   done              : one-cycle completion pulse
//   cksum             : sum of copied words (only with MEM_BLOCK_MOVER_CKSUM_EN)
//   mem               : memory bus, master side
// Optional feature macro: MEM_BLOCK_MOVER_CKSUM_EN
// Revision    : 1.0 - initial release
// ============================================================================
module mem_block_mover
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 0
) (
    input  wire                clk,
    input  wire                rst,
    input  wire                start,
    input  wire   [ADDR_W-1:0] src_addr,
    input  wire   [ADDR_W-1:0] dst_addr,
    input  wire   [15:0]       len,
    output logic               busy,
    output logic               done,
`ifdef MEM_BLOCK_MOVER_CKSUM_EN
    output logic  [DATA_W-1:0] cksum,
`endif
    mem_block_mover_if.master  mem
);

    localparam int c_EXT_W = ADDR_W + 1;
    localparam logic [WAIT_CNT_W-1:0] c_WAIT_LAST = WAIT_CNT_W'(RD_LAT - 1);

    state_t                r_state;
    logic [15:0]           r_remaining;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_desc;

    logic [ADDR_W-1:0]     w_len_a;
    logic [c_EXT_W-1:0]    w_src_end;
    logic                  w_desc;
    logic [ADDR_W-1:0]     w_src_first;
    logic [ADDR_W-1:0]     w_dst_first;
    logic [ADDR_W-1:0]     w_src_ptr;
    logic [ADDR_W-1:0]     w_dst_ptr;
    logic                  w_accept;
    logic                  w_capture;

    // Overlap test is done one bit wider so src+len cannot wrap; a copy whose
    // destination sits inside the source tail must run back-to-front.
    assign w_len_a     = ADDR_W'(len);
    assign w_src_end   = c_EXT_W'(src_addr) + c_EXT_W'(len);
    assign w_desc      = (dst_addr > src_addr) && (c_EXT_W'(dst_addr) < w_src_end);
    assign w_src_first = w_desc ? (src_addr + w_len_a - ADDR_W'(1)) : src_addr;
    assign w_dst_first = w_desc ? (dst_addr + w_len_a - ADDR_W'(1)) : dst_addr;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_capture = (RD_LAT == 0) ? (r_state == ST_READ)
                                     : ((r_state == ST_WAIT) && (r_wait_cnt == c_WAIT_LAST));

    // The source pointer advances as soon as its word is captured, so it is
    // already on the next word when WRITE hands the bus back to READ. The
    // destination pointer advances with each WRITE.
    mem_addr_stepper #(.ADDR_W(ADDR_W)) u_src_ptr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     (w_capture),
        .i_up       (~r_desc),
        .i_load_val (w_src_first),
        .o_ptr      (w_src_ptr)
    );

    mem_addr_stepper #(.ADDR_W(ADDR_W)) u_dst_ptr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     (r_state == ST_WRITE),
        .i_up       (~r_desc),
        .i_load_val (w_dst_first),
        .o_ptr      (w_dst_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_wait_cnt    <= '0;
            r_desc        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_write <= 1'b0;
            mem.mem_read  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_remaining <= len;
                        r_desc      <= w_desc;
                        if (len == 16'd0) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state      <= ST_READ;
                            busy         <= 1'b1;
                            mem.mem_read <= 1'b1;
                            mem.mem_addr <= w_src_first;
                        end
                    end
                end
                ST_READ, ST_WAIT: begin
                    mem.mem_read <= 1'b0;
                    if (w_capture) begin
                        mem.mem_wdata <= mem.mem_rdata;
                        mem.mem_write <= 1'b1;
                        mem.mem_addr  <= w_dst_ptr;
                        r_state       <= ST_WRITE;
                    end else if (r_state == ST_READ) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    mem.mem_write <= 1'b0;
                    r_remaining   <= r_remaining - 16'd1;
                    if (r_remaining == 16'd1) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state      <= ST_READ;
                        mem.mem_read <= 1'b1;
                        mem.mem_addr <= w_src_ptr;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_BLOCK_MOVER_CKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            cksum <= '0;
        end else if (w_capture) begin
            cksum <= cksum + mem.mem_rdata;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_block_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_block_mover
// Description : Two movers (RD_LAT=0 and RD_LAT=2), each attached to its own
//               behavioural DataMemory. Directed and random copies are
//               compared against a word-by-word reference copy, plus timing,
//               strobe, reset and checksum (MEM_BLOCK_MOVER_CKSUM_EN) checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_block_mover;
    import mem_pkg::*;

    localparam int c_AW = 16;
    localparam int c_DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst2, start0, start2;
    logic [15:0] src, dst, len;
    logic        busy0, done0, busy2, done2;
`ifdef MEM_BLOCK_MOVER_CKSUM_EN
    logic [15:0] cksum0, cksum2;
`endif

    mem_block_mover_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) mif0 ();
    mem_block_mover_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) mif2 ();

    mem_block_mover #(.ADDR_W(c_AW), .DATA_W(c_DW), .RD_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst0), .start(start0), .src_addr(src), .dst_addr(dst),
        .len(len), .busy(busy0), .done(done0),
`ifdef MEM_BLOCK_MOVER_CKSUM_EN
        .cksum(cksum0),
`endif
        .mem(mif0)
    );

    mem_block_mover #(.ADDR_W(c_AW), .DATA_W(c_DW), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst2), .start(start2), .src_addr(src), .dst_addr(dst),
        .len(len), .busy(busy2), .done(done2),
`ifdef MEM_BLOCK_MOVER_CKSUM_EN
        .cksum(cksum2),
`endif
        .mem(mif2)
    );

    // Behavioural DataMemory models; a side port preloads words while idle.
    logic [15:0] mem0    [0:65535];
    logic [15:0] mem2    [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] r_p1, r_p2;
    logic        pl_we0, pl_we2;
    logic [15:0] pl_addr, pl_data;

    always @(posedge clk) begin
        if (mif0.mem_write)   mem0[mif0.mem_addr] <= mif0.mem_wdata;
        else if (pl_we0)      mem0[pl_addr]       <= pl_data;
    end
    assign mif0.mem_rdata = mif0.mem_read ? mem0[mif0.mem_addr] : 16'h0000;

    always @(posedge clk) begin
        if (mif2.mem_write)   mem2[mif2.mem_addr] <= mif2.mem_wdata;
        else if (pl_we2)      mem2[pl_addr]       <= pl_data;
        r_p1 <= mif2.mem_read ? mem2[mif2.mem_addr] : 16'h0000;
        r_p2 <= r_p1;
    end
    assign mif2.mem_rdata = r_p2;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_mem(input int which, input logic [15:0] a);
        return (which == 0) ? mem0[a] : mem2[a];
    endfunction

    function automatic logic cur_done(input int which);
        return (which == 0) ? done0 : done2;
    endfunction
    function automatic logic cur_busy(input int which);
        return (which == 0) ? busy0 : busy2;
    endfunction
    function automatic logic cur_rd(input int which);
        return (which == 0) ? mif0.mem_read : mif2.mem_read;
    endfunction
    function automatic logic cur_wr(input int which);
        return (which == 0) ? mif0.mem_write : mif2.mem_write;
    endfunction

    // Called and returns at a falling edge.
    task automatic poke(input int which, input logic [15:0] a, input logic [15:0] v);
        pl_addr = a;
        pl_data = v;
        if (which == 0) pl_we0 = 1'b1; else pl_we2 = 1'b1;
        @(negedge clk);
        pl_we0 = 1'b0;
        pl_we2 = 1'b0;
    endtask

    // One complete copy, checked against a reference copy that walks the
    // words in the order the direction rule dictates.
    task automatic run_copy(input int which, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] n, input bit poke_busy);
        int          lat;
        int          exp_cyc;
        int          idx;
        int          cyc;
        int          n_rd, n_wr, n_both, n_busy;
        bit          desc, seen;
        logic [15:0] v, sum, a;
        lat     = (which == 0) ? 0 : 2;
        exp_cyc = 1 + int'(n) * (2 + lat);
        if (which == 0) ref_mem = mem0; else ref_mem = mem2;
        desc = (int'(d) > int'(s)) && (int'(d) < int'(s) + int'(n));
        sum  = 16'h0000;
        for (int i = 0; i < int'(n); i++) begin
            idx = desc ? (int'(n) - 1 - i) : i;
            v   = ref_mem[16'(int'(s) + idx)];
            ref_mem[16'(int'(d) + idx)] = v;
            sum = sum + v;
        end

        src = s; dst = d; len = n;
        if (which == 0) start0 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start2 = 1'b0;
        cyc = 1; seen = 1'b0;
        n_rd = 0; n_wr = 0; n_both = 0; n_busy = 0;
        while (!seen && cyc <= exp_cyc + 20) begin
            if (cur_busy(which)) n_busy++;
            if (cur_rd(which)) n_rd++;
            if (cur_wr(which)) n_wr++;
            if (cur_rd(which) && cur_wr(which)) n_both++;
            if (cur_done(which)) begin
                seen = 1'b1;
            end else begin
                if (poke_busy && cyc == 2) begin
                    src = 16'h7000; dst = 16'h7100; len = 16'd3;
                    if (which == 0) start0 = 1'b1; else start2 = 1'b1;
                end
                @(negedge clk);
                start0 = 1'b0; start2 = 1'b0;
                cyc++;
            end
        end
        check_val("done_seen", seen, 1'b1);
        if (seen) check_val("done_cycle", cyc, exp_cyc);
        check_val("strobes_both", n_both, 0);
        check_val("read_count", n_rd, int'(n));
        check_val("write_count", n_wr, int'(n));
        check_val("busy_cycles", n_busy, exp_cyc - 1);
`ifdef MEM_BLOCK_MOVER_CKSUM_EN
        check_val("cksum", (which == 0) ? cksum0 : cksum2, sum);
`endif
        for (int i = 0; i < int'(n); i++) begin
            a = 16'(int'(d) + i);
            check_val($sformatf("dst_word[%0h]", a), rd_mem(which, a), ref_mem[a]);
        end
        a = d - 16'd1;
        check_val("below_dst", rd_mem(which, a), ref_mem[a]);
        a = d + n;
        check_val("above_dst", rd_mem(which, a), ref_mem[a]);
        @(negedge clk);
        check_val("done_one_cycle", cur_done(which), 1'b0);
    endtask

    int          ndone;
    logic [15:0] rs, rd, rn;
    int          mode;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1; rst2 = 1'b1; start0 = 1'b0; start2 = 1'b0;
        src = '0; dst = '0; len = '0;
        pl_we0 = 1'b0; pl_we2 = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy0", busy0, 1'b0);
        check_val("rst_done0", done0, 1'b0);
        check_val("rst_rd0", mif0.mem_read, 1'b0);
        check_val("rst_wr0", mif0.mem_write, 1'b0);
        check_val("rst_addr0", mif0.mem_addr, 16'h0000);
        check_val("rst_wdata0", mif0.mem_wdata, 16'h0000);
        check_val("rst_busy2", busy2, 1'b0);
        check_val("rst_done2", done2, 1'b0);
        check_val("rst_addr2", mif2.mem_addr, 16'h0000);
        rst0 = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        // Basic forward copy.
        for (int i = 1; i <= 15; i++) poke(0, 16'(i), 16'(i + 1));
        run_copy(0, 16'h0001, 16'h0020, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++)
            check_val("basic_const", mem0[16'(32 + i)], 16'(2 + i));

        // Overlapping forward copy must not smear.
        run_copy(0, 16'h0001, 16'h0003, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++)
            check_val("overlap_const", mem0[16'(3 + i)], 16'(2 + i));
        check_val("overlap_src1", mem0[16'h0001], 16'h0002);
        check_val("overlap_src2", mem0[16'h0002], 16'h0003);

        // Zero-length copy.
        run_copy(0, 16'h0040, 16'h0080, 16'd0, 1'b0);

        // Source wraps through the top of the address space.
        poke(0, 16'hFFFE, 16'hAAAA);
        poke(0, 16'hFFFF, 16'hBBBB);
        poke(0, 16'h0000, 16'hCCCC);
        run_copy(0, 16'hFFFE, 16'h0100, 16'd3, 1'b0);
        check_val("wrap_0", mem0[16'h0100], 16'hAAAA);
        check_val("wrap_1", mem0[16'h0101], 16'hBBBB);
        check_val("wrap_2", mem0[16'h0102], 16'hCCCC);

        // Reset during the second WRITE of an 8-word copy.
        for (int i = 0; i < 8; i++) poke(0, 16'(16'h0200 + i), 16'($urandom));
        src = 16'h0200; dst = 16'h0300; len = 16'd8; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mid_in_write", mif0.mem_write, 1'b1);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        check_val("mid_rst_rd", mif0.mem_read, 1'b0);
        check_val("mid_rst_wr", mif0.mem_write, 1'b0);
        check_val("mid_rst_busy", busy0, 1'b0);
        check_val("mid_rst_done", done0, 1'b0);
        check_val("mid_rst_addr", mif0.mem_addr, 16'h0000);
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done0 || busy0) ndone++;
        end
        check_val("mid_rst_quiet", ndone, 0);

        // Start together with reset is dropped.
        rst0 = 1'b1; start0 = 1'b1; len = 16'd2;
        @(negedge clk);
        rst0 = 1'b0; start0 = 1'b0;
        check_val("rst_start_busy", busy0, 1'b0);
        @(negedge clk);
        check_val("rst_start_rd", mif0.mem_read, 1'b0);

        // Fresh copy after reset, with an ignored start pulsed while busy.
        run_copy(0, 16'h0200, 16'h0300, 16'd8, 1'b1);

        // Slow memory copy (checksum 5+6+FFFF wraps to 000A).
        poke(2, 16'h0010, 16'h0005);
        poke(2, 16'h0011, 16'h0006);
        poke(2, 16'h0012, 16'hFFFF);
        run_copy(2, 16'h0010, 16'h0020, 16'd3, 1'b0);
`ifdef MEM_BLOCK_MOVER_CKSUM_EN
        check_val("cksum_const", cksum2, 16'h000A);
`endif
        run_copy(2, 16'h0010, 16'h0011, 16'd3, 1'b1);

        // Random copies on both movers.
        for (int w = 0; w < 2; w++) begin
            for (int t = 0; t < 8; t++) begin
                rs   = 16'($urandom);
                rn   = 16'($urandom_range(0, 10));
                mode = $urandom_range(0, 2);
                if (mode == 0 || rn == 16'd0) rd = rs + 16'($urandom_range(16, 1000));
                else if (mode == 1)           rd = rs + 16'($urandom_range(1, int'(rn)));
                else                          rd = rs - 16'($urandom_range(0, int'(rn)));
                for (int i = 0; i < int'(rn); i++)
                    poke(w * 2, 16'(int'(rs) + i), 16'($urandom));
                run_copy(w * 2, rs, rd, rn, t[0]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
